// File: rtl/readout_router_rr.sv
// readout_router_rr: arbitrates tagged words from NCH source channels into a
// 2^AW-entry FIFO and presents them on a registered output port. Spin-flip
// words (FLIP_TAG) stay on the output until response_in acknowledges them.
// Optional feature macro: ROUTER_RR_EN selects round-robin arbitration.
// Without it, the arbiter uses fixed priority and the lowest index wins.
//
// Handshake: a channel requests while its tag is neither IDLE_TAG nor 0.
// It must hold its word until it sees its in_ack bit high. in_ack is
// combinational, one-hot, and forced to 0 while the FIFO is full. The acked
// word is written into the FIFO on the same rising edge.
module readout_router_rr #(
  parameter int         DW       = 32,
  parameter int         NCH      = 5,
  parameter int         AW       = 2,
  parameter logic [2:0] IDLE_TAG = 3'd5,
  parameter logic [2:0] FLIP_TAG = 3'd6
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NCH*DW-1:0] din,
  output logic [NCH-1:0]    in_ack,
  input  logic              response_in,
  output logic [DW-1:0]     dout,
  output logic              dout_valid,
  output logic              full,
  output logic              empty,
  output logic [AW:0]       count
);

  localparam int DEPTH = 1 << AW;

  logic [NCH-1:0] req;
  logic [DW-1:0]  push_data;
  logic [AW:0]    wr_ptr;
  logic [AW:0]    rd_ptr;
  logic [DW-1:0]  mem [DEPTH];
  logic           push;
  logic           pop;
  logic           hold;

  // Request decode: a channel requests when its tag is neither idle nor zero.
  always_comb begin
    req = '0;
    for (int i = 0; i < NCH; i++) begin
      req[i] = (din[i*DW + DW - 1 -: 3] != IDLE_TAG) &&
               (din[i*DW + DW - 1 -: 3] != 3'd0);
    end
  end

`ifdef ROUTER_RR_EN
  localparam int LGW = (NCH > 1) ? $clog2(NCH) : 1;

  logic [LGW-1:0] last_grant;
  logic [LGW-1:0] grant_idx;
  logic           grant_any;

  // Round-robin grant: the search starts just after the last granted channel.
  always_comb begin
    int idx;
    in_ack    = '0;
    grant_idx = last_grant;
    grant_any = 1'b0;
    idx       = 0;
    if (!full) begin
      for (int k = 1; k <= NCH; k++) begin
        idx = (int'(last_grant) + k) % NCH;
        if (!grant_any && req[idx]) begin
          grant_any   = 1'b1;
          grant_idx   = LGW'(idx);
          in_ack[idx] = 1'b1;
        end
      end
    end
  end

  // The last-grant pointer moves only when a grant is actually issued.
  always_ff @(posedge clk) begin
    if (rst) begin
      last_grant <= LGW'(NCH - 1);
    end else if (grant_any) begin
      last_grant <= grant_idx;
    end
  end
`else
  // Fixed-priority grant: the lowest requesting index wins. No pointer is kept.
  always_comb begin
    logic found;
    in_ack = '0;
    found  = 1'b0;
    if (!full) begin
      for (int i = 0; i < NCH; i++) begin
        if (!found && req[i]) begin
          found     = 1'b1;
          in_ack[i] = 1'b1;
        end
      end
    end
  end
`endif

  // Mux the granted channel's word onto the FIFO write port.
  always_comb begin
    push_data = '0;
    for (int i = 0; i < NCH; i++) begin
      if (in_ack[i]) begin
        push_data = din[i*DW +: DW];
      end
    end
  end

  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign empty = (wr_ptr == rd_ptr);
  assign count = wr_ptr - rd_ptr;

  // A presented flip word blocks the output until it is acknowledged.
  assign hold = dout_valid && (dout[DW-1 -: 3] == FLIP_TAG) && !response_in;
  assign push = |in_ack;
  assign pop  = !empty && !hold;

  // FIFO pointers: the extra MSB distinguishes full from empty.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // FIFO storage is written without reset; the pointers qualify its contents.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr[AW-1:0]] <= push_data;
    end
  end

  // Output register: hold a flip word, else load the FIFO head, else go idle.
  always_ff @(posedge clk) begin
    if (rst) begin
      dout       <= '0;
      dout_valid <= 1'b0;
    end else if (hold) begin
      dout       <= dout;
      dout_valid <= dout_valid;
    end else if (!empty) begin
      dout       <= mem[rd_ptr[AW-1:0]];
      dout_valid <= 1'b1;
    end else begin
      dout       <= '0;
      dout_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_readout_router_rr.sv
// tb_readout_router_rr: directed bench for readout_router_rr. A scoreboard
// queue holds words in the order they were accepted. A monitor pops one entry
// each time a new word is presented and checks held flip words for stability.
module tb_readout_router_rr;

  localparam int DW  = 32;
  localparam int NCH = 5;
  localparam int AW  = 2;
  localparam logic [2:0] FLIP = 3'd6;

  logic              clk;
  logic              rst;
  logic [NCH*DW-1:0] din;
  logic [NCH-1:0]    in_ack;
  logic              response_in;
  logic [DW-1:0]     dout;
  logic              dout_valid;
  logic              full;
  logic              empty;
  logic [AW:0]       count;

  logic [DW-1:0] exp_q[$];
  logic [DW-1:0] last_exp;
  int checks = 0;
  int errors = 0;

  readout_router_rr #(.DW(DW), .NCH(NCH), .AW(AW)) dut (
    .clk(clk), .rst(rst), .din(din), .in_ack(in_ack),
    .response_in(response_in), .dout(dout), .dout_valid(dout_valid),
    .full(full), .empty(empty), .count(count)
  );

  // Clock and time limit.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, errors=%0d", errors);
    $fatal(1, "timeout");
  end

  task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Scoreboard monitor: work out at the edge whether the output was held,
  // then check the presented word half a cycle later.
  initial begin
    logic was_hold;
    logic was_rst;
    last_exp = '0;
    forever begin
      @(posedge clk);
      was_hold = (dout_valid === 1'b1) && (dout[DW-1 -: 3] === FLIP) && (response_in !== 1'b1);
      was_rst  = rst;
      @(negedge clk);
      if (was_rst) begin
        last_exp = '0;
      end else if (was_hold) begin
        chk("mon_hold_valid", DW'(dout_valid), 32'd1);
        chk("mon_hold_word", dout, last_exp);
      end else if (dout_valid === 1'b1) begin
        if (exp_q.size() == 0) begin
          chk("mon_unexpected_word", dout, 32'd0);
        end else begin
          last_exp = exp_q.pop_front();
          chk("mon_word", dout, last_exp);
        end
      end else begin
        chk("mon_idle_dout_zero", dout, 32'd0);
      end
    end
  end

  // Hold reset for one cycle from the current negedge and flush the scoreboard.
  task automatic do_reset();
    rst = 1'b1;
    din = '0;
    response_in = 1'b0;
    exp_q.delete();
    @(negedge clk);
    rst = 1'b0;
  endtask

  // Offer one word on one channel until it is accepted (bounded), then score it.
  task automatic send(input int ch, input logic [DW-1:0] w);
    logic [NCH-1:0] oh;
    int n;
    oh = '0;
    oh[ch] = 1'b1;
    n = 0;
    @(negedge clk);
    din = '0;
    din[ch*DW +: DW] = w;
    #1;
    while (in_ack !== oh && n < 20) begin
      @(negedge clk);
      #1;
      n++;
    end
    chk("send_ack", DW'(in_ack), DW'(oh));
    if (in_ack === oh) exp_q.push_back(w);
  endtask

  task automatic idle();
    @(negedge clk);
    din = '0;
  endtask

  // Wait until every scored word has been presented (bounded).
  task automatic drain();
    int n;
    n = 0;
    while ((exp_q.size() != 0 || dout_valid === 1'b1) && n < 60) begin
      @(negedge clk);
      n++;
    end
    chk("drain_queue_empty", DW'(exp_q.size()), 32'd0);
    chk("drain_count_zero", DW'(count), 32'd0);
  endtask

  initial begin
    logic [DW-1:0]  w [NCH];
    logic [NCH-1:0] exp_oh;
    int seq;
    int exp_ch;

    rst = 1'b1;
    din = '0;
    response_in = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;

    // Reset state.
    #1;
    chk("rst_in_ack", DW'(in_ack), 32'd0);
    chk("rst_full", DW'(full), 32'd0);
    chk("rst_empty", DW'(empty), 32'd1);
    chk("rst_count", DW'(count), 32'd0);
    chk("rst_dout_valid", DW'(dout_valid), 32'd0);
    chk("rst_dout", dout, 32'd0);

    // Single word from channel 2: accepted at t, presented at t+2 for one cycle.
    @(negedge clk);
    din[2*DW +: DW] = 32'h4000_0123;
    #1;
    chk("single_ack", DW'(in_ack), 32'b00100);
    exp_q.push_back(32'h4000_0123);
    @(negedge clk);
    din = '0;
    chk("single_t1_count", DW'(count), 32'd1);
    chk("single_t1_valid", DW'(dout_valid), 32'd0);
    @(negedge clk);
    chk("single_t2_valid", DW'(dout_valid), 32'd1);
    chk("single_t2_dout", dout, 32'h4000_0123);
    chk("single_t2_count", DW'(count), 32'd0);
    @(negedge clk);
    chk("single_t3_valid", DW'(dout_valid), 32'd0);
    chk("single_t3_empty", DW'(empty), 32'd1);

    // Arbitration: all channels request continuously.
    do_reset();
    seq = 0;
    for (int ch = 0; ch < NCH; ch++) begin
      w[ch] = {3'd1, 5'(ch), 24'(seq)};
      seq++;
    end
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      for (int ch = 0; ch < NCH; ch++) din[ch*DW +: DW] = w[ch];
      #1;
`ifdef ROUTER_RR_EN
      exp_ch = c % NCH;
`else
      exp_ch = 0;
`endif
      exp_oh = '0;
      exp_oh[exp_ch] = 1'b1;
      chk("arb_grant", DW'(in_ack), DW'(exp_oh));
      for (int ch = 0; ch < NCH; ch++) begin
        if (in_ack[ch] === 1'b1) begin
          exp_q.push_back(w[ch]);
          w[ch] = {3'd1, 5'(ch), 24'(seq)};
          seq++;
        end
      end
    end
    idle();
    drain();

    // Idle and zero tags never request.
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      for (int ch = 0; ch < NCH; ch++) begin
        din[ch*DW +: DW] = {((ch + c) % 2 == 0) ? 3'd5 : 3'd0, 29'($urandom_range(0, 32'h1FFF_FFFF))};
      end
      #1;
      chk("idle_in_ack", DW'(in_ack), 32'd0);
    end
    @(negedge clk);
    chk("idle_count", DW'(count), 32'd0);
    chk("idle_dout", dout, 32'd0);
    din = '0;

    // Stall behind a held flip word until the FIFO is full.
    send(0, 32'hC000_0001);
    send(1, 32'h2000_0A01);
    send(1, 32'h2000_0A02);
    send(1, 32'h2000_0A03);
    send(1, 32'h2000_0A04);
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      din = '0;
      din[1*DW +: DW] = 32'h2000_0A05;
      #1;
      chk("stall_in_ack", DW'(in_ack), 32'd0);
      chk("stall_full", DW'(full), 32'd1);
      chk("stall_count", DW'(count), 32'd4);
      chk("stall_dout", dout, 32'hC000_0001);
    end
    response_in = 1'b1;
    @(negedge clk);
    response_in = 1'b0;
    chk("stall_next_word", dout, 32'h2000_0A01);
    chk("stall_count_after_pop", DW'(count), 32'd3);
    #1;
    chk("stall_ack_after_pop", DW'(in_ack), 32'b00010);
    if (in_ack === 5'b00010) exp_q.push_back(32'h2000_0A05);
    idle();
    drain();

    // Flip hold for 10 cycles, acknowledge on the 11th.
    send(3, 32'hC000_0002);
    send(4, 32'h2000_00AA);
    idle();
    for (int n = 0; n < 10 && dout_valid !== 1'b1; n++) @(negedge clk);
    for (int c = 0; c < 10; c++) begin
      chk("flip_hold_dout", dout, 32'hC000_0002);
      chk("flip_hold_valid", DW'(dout_valid), 32'd1);
      @(negedge clk);
    end
    chk("flip_hold_c11", dout, 32'hC000_0002);
    response_in = 1'b1;
    @(negedge clk);
    response_in = 1'b0;
    chk("flip_release_next", dout, 32'h2000_00AA);
    chk("flip_release_valid", DW'(dout_valid), 32'd1);
    drain();

    // Reset while a flip word is held and three words are buffered.
    send(0, 32'hC000_0003);
    send(1, 32'h2000_0B01);
    send(2, 32'h2000_0B02);
    send(3, 32'h2000_0B03);
    idle();
    chk("midrst_pre_count", DW'(count), 32'd3);
    chk("midrst_pre_dout", dout, 32'hC000_0003);
    do_reset();
    chk("midrst_count", DW'(count), 32'd0);
    chk("midrst_empty", DW'(empty), 32'd1);
    chk("midrst_valid", DW'(dout_valid), 32'd0);
    chk("midrst_dout", dout, 32'd0);
    repeat (3) @(negedge clk);
    chk("midrst_stays_idle", DW'(dout_valid), 32'd0);
    chk("final_queue_empty", DW'(exp_q.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
